// File: rtl/act_read_sequencer_if.sv
// Bus bundle for the activation read sequencer: job control from the tile
// scheduler, fill notifications from the DMA, and the buffer read port.
interface act_read_sequencer_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DRAIN_W    = 5,
   parameter int TILE_W     = 8
);
   logic                  start;
   logic [ADDR_WIDTH:0]   k_len;
   logic [DRAIN_W-1:0]    drain_len;
   logic [TILE_W-1:0]     num_tiles;
   logic                  fill_done;
   logic                  fill_bank;
   logic [1:0]            bank_full;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] k_idx;
   logic                  bank_sel_rd;
   logic                  a_valid;
   logic                  a_last;
   logic                  busy;
   logic                  done;
   logic                  err;

   modport master (
      output start, k_len, drain_len, num_tiles, fill_done, fill_bank,
      input  bank_full, rd_en, k_idx, bank_sel_rd, a_valid, a_last, busy, done, err
   );

   modport slave (
      input  start, k_len, drain_len, num_tiles, fill_done, fill_bank,
      output bank_full, rd_en, k_idx, bank_sel_rd, a_valid, a_last, busy, done, err
   );
endinterface

// File: rtl/act_read_sequencer.sv
// Read-side controller for the ping-pong activation SRAM: waits for a full
// bank, streams K rows of a tile from it, drains, then hands the bank back.
module act_read_sequencer #(
   parameter int ADDR_WIDTH = 7,
   parameter int DRAIN_W    = 5,
   parameter int TILE_W     = 8
) (
   input logic                clk,
   input logic                rst_n,
   act_read_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, WAIT_BANK, STREAM, DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] ROW_ONE   = ADDR_WIDTH'(1);
   localparam logic [DRAIN_W-1:0]    DRAIN_ONE = DRAIN_W'(1);
   localparam logic [TILE_W-1:0]     TILE_ONE  = TILE_W'(1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] k_last_q;
   logic [ADDR_WIDTH-1:0] row;
   logic [DRAIN_W-1:0]    drain_len_q;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic [TILE_W-1:0]     tiles_left;
   logic                  cur_bank;

   logic                  k_len_legal;
   logic                  start_ok;
   logic                  row_last;
   logic                  drain_end;
   logic                  last_tile;

   logic                  rd_en_q, rd_en_nxt;
   logic [ADDR_WIDTH-1:0] k_idx_q, k_idx_nxt;
   logic                  bank_sel_q, bank_sel_nxt;
   logic                  last_q, last_nxt;
   logic                  a_valid_q, a_last_q;
   logic                  busy_q, busy_nxt;
   logic                  done_q, done_nxt;
   logic                  err_q, err_nxt;
   logic [1:0]            bank_full_q, bank_full_nxt;
   logic [1:0]            set_mask, rel_mask;

   // k_len > depth is exactly "MSB set with any lower bit set"
   assign k_len_legal = (bus.k_len != '0) &&
                        !(bus.k_len[ADDR_WIDTH] && (bus.k_len[ADDR_WIDTH-1:0] != '0));
   assign start_ok    = (state == IDLE) && bus.start && k_len_legal;
   assign row_last    = (row == k_last_q);
   assign drain_end   = (state == DRAIN) && (drain_cnt == '0);
   assign last_tile   = (tiles_left == TILE_ONE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start_ok && (bus.num_tiles != '0)) state_nxt = WAIT_BANK;
         WAIT_BANK: if (bank_full_q[cur_bank])            state_nxt = STREAM;
         STREAM:    if (row_last)                         state_nxt = DRAIN;
         DRAIN:     if (drain_cnt == '0)                  state_nxt = last_tile ? IDLE : WAIT_BANK;
         default:                                          state_nxt = IDLE;
      endcase
   end

   // job parameters, row/drain counters and bank pointer
   // k_last is stored as k_len-1 in ADDR_WIDTH bits; k_len=2**ADDR_WIDTH wraps to all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_last_q    <= '0;
         drain_len_q <= '0;
         tiles_left  <= '0;
         row         <= '0;
         drain_cnt   <= '0;
         cur_bank    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok && (bus.num_tiles != '0)) begin
                  k_last_q    <= bus.k_len[ADDR_WIDTH-1:0] - ROW_ONE;
                  drain_len_q <= bus.drain_len;
                  tiles_left  <= bus.num_tiles;
                  cur_bank    <= 1'b0;
               end
            end
            WAIT_BANK: begin
               if (bank_full_q[cur_bank]) row <= '0;
            end
            STREAM: begin
               if (row_last) drain_cnt <= drain_len_q;
               else          row       <= row + ROW_ONE;
            end
            DRAIN: begin
               if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - DRAIN_ONE;
               end else begin
                  cur_bank   <= ~cur_bank;
                  tiles_left <= tiles_left - TILE_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // next values for the registered outputs and bank ownership flags
   always_comb begin
      rd_en_nxt    = (state == STREAM);
      k_idx_nxt    = (state == STREAM) ? row : k_idx_q;
      bank_sel_nxt = (state == STREAM) ? cur_bank : bank_sel_q;
      last_nxt     = (state == STREAM) && row_last;
      done_nxt     = (start_ok && (bus.num_tiles == '0)) || (drain_end && last_tile);
      busy_nxt     = (state_nxt != IDLE);
      set_mask     = '0;
      if (bus.fill_done) set_mask[bus.fill_bank] = 1'b1;
      rel_mask     = '0;
      if (drain_end) rel_mask[cur_bank] = 1'b1;
      // a fill landing on a bank in the same cycle it is released still leaves it full
      bank_full_nxt = (bank_full_q & ~rel_mask) | set_mask;
      err_nxt       = err_q ||
                      ((state == IDLE) && bus.start && !k_len_legal) ||
                      (bus.fill_done && bank_full_q[bus.fill_bank]);
   end

   // output registers; a_valid/a_last trail rd_en by the buffer's 1-cycle latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q     <= 1'b0;
         k_idx_q     <= '0;
         bank_sel_q  <= 1'b0;
         last_q      <= 1'b0;
         a_valid_q   <= 1'b0;
         a_last_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         bank_full_q <= '0;
      end else begin
         rd_en_q     <= rd_en_nxt;
         k_idx_q     <= k_idx_nxt;
         bank_sel_q  <= bank_sel_nxt;
         last_q      <= last_nxt;
         a_valid_q   <= rd_en_q;
         a_last_q    <= rd_en_q && last_q;
         busy_q      <= busy_nxt;
         done_q      <= done_nxt;
         err_q       <= err_nxt;
         bank_full_q <= bank_full_nxt;
      end
   end

   assign bus.rd_en       = rd_en_q;
   assign bus.k_idx       = k_idx_q;
   assign bus.bank_sel_rd = bank_sel_q;
   assign bus.a_valid     = a_valid_q;
   assign bus.a_last      = a_last_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.bank_full   = bank_full_q;

endmodule
